// File: rtl/ql_episode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ql_episode_ctrl_pkg
//  Purpose  : Shared widths, defaults, controller state encoding and the
//             LFSR step function for the Q-learning episode controller.
//  Revision : 1.0  initial release
// ============================================================================
package ql_episode_ctrl_pkg;

   localparam int STATES_WIDTH  = 4;
   localparam int ACTIONS_WIDTH = 2;
   localparam int COUNTER_WIDTH = 16;
   localparam int NUM_ACTIONS   = 3;
   localparam int GOAL_STATE    = 15;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      EP_START   = 3'd1,
      STEP       = 3'd2,
      WAIT_AGENT = 3'd3,
      UPDATE     = 3'd4,
      CHECK      = 3'd5,
      DONE       = 3'd6
   } ctrl_state_t;

   // One step of a right-shifting Galois LFSR, taps 16,14,13,11.
   function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ql_episode_ctrl_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : ql_lfsr16
//  Purpose  : 16-bit Galois LFSR with reset seed and advance enable.
//  Revision : 1.0  initial release
// ============================================================================
module ql_lfsr16
   import ql_episode_ctrl_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_advance,
   output logic [15:0] o_lfsr
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Advance by one step on each enabled cycle, otherwise hold.
   always_comb begin
      lfsr_d = lfsr_q;
      if (i_advance) begin
         lfsr_d = lfsr16_next(lfsr_q);
      end
   end

   // State register; the seed must be nonzero or the sequence locks up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign o_lfsr = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/ql_episode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ql_episode_ctrl
//  Purpose  : Episode/step sequencer for the Q-learning agent. Requests one
//             agent step at a time, forwards each transition to the Q-update
//             unit over valid/ready, ends episodes on goal or step limit and
//             supplies the random action source.
//  Revision : 1.0  initial release
// ============================================================================
module ql_episode_ctrl
   import ql_episode_ctrl_pkg::*;
#(
   parameter int          NUM_ACTIONS  = ql_episode_ctrl_pkg::NUM_ACTIONS,
   parameter int          MAX_STEPS    = 64,
   parameter int          MAX_EPISODES = 300,
   parameter int          GOAL_STATE   = ql_episode_ctrl_pkg::GOAL_STATE,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_start,
   input  logic                     i_stop,
   input  logic [STATES_WIDTH-1:0]  i_first_st,
   output logic                     o_agent_valid,
   output logic [STATES_WIDTH-1:0]  o_agent_st,
   output logic [COUNTER_WIDTH-1:0] o_count,
   output logic [ACTIONS_WIDTH-1:0] o_at_random,
   input  logic                     i_re_random,
   input  logic                     i_agent_valid,
   input  logic [STATES_WIDTH-1:0]  i_st,
   input  logic [STATES_WIDTH-1:0]  i_next_st,
   input  logic [ACTIONS_WIDTH-1:0] i_at,
   output logic                     o_upd_valid,
   output logic [STATES_WIDTH-1:0]  o_upd_st,
   output logic [STATES_WIDTH-1:0]  o_upd_next_st,
   output logic [ACTIONS_WIDTH-1:0] o_upd_at,
   input  logic                     i_upd_ready,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_err
);

   // The step counter only has to reach MAX_STEPS: the limit ends the episode.
   localparam int STEP_W = $clog2(MAX_STEPS + 1);
   localparam logic [STEP_W-1:0]        C_MAX_STEPS = STEP_W'(MAX_STEPS);
   localparam logic [COUNTER_WIDTH-1:0] C_LAST_EP   = COUNTER_WIDTH'(MAX_EPISODES - 1);
   localparam logic [STATES_WIDTH-1:0]  C_GOAL      = STATES_WIDTH'(GOAL_STATE);

   ctrl_state_t               state_q,    state_d;
   logic [STEP_W-1:0]         step_cnt_q, step_cnt_d;
   logic [STATES_WIDTH-1:0]   cur_st_q,   cur_st_d;
   logic [COUNTER_WIDTH-1:0]  count_q,    count_d;
   logic [STATES_WIDTH-1:0]   upd_st_q,   upd_st_d;
   logic [STATES_WIDTH-1:0]   upd_next_q, upd_next_d;
   logic [ACTIONS_WIDTH-1:0]  upd_at_q,   upd_at_d;
   logic                      err_q,      err_d;
   logic [15:0]               lfsr_state;

   // Next-state, counters, transition capture and sticky error.
   always_comb begin
      state_d    = state_q;
      step_cnt_d = step_cnt_q;
      cur_st_d   = cur_st_q;
      count_d    = count_q;
      upd_st_d   = upd_st_q;
      upd_next_d = upd_next_q;
      upd_at_d   = upd_at_q;
      err_d      = err_q;

      case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               count_d = '0;
               state_d = EP_START;
            end
         end
         EP_START: begin
            step_cnt_d = '0;
            cur_st_d   = i_first_st;
            state_d    = STEP;
         end
         STEP: begin
            step_cnt_d = step_cnt_q + 1'b1;
            state_d    = WAIT_AGENT;
         end
         WAIT_AGENT: begin
            if (i_agent_valid) begin
               upd_st_d   = i_st;
               upd_at_d   = i_at;
               upd_next_d = i_next_st;
               state_d    = UPDATE;
            end
         end
         UPDATE: begin
            if (i_upd_ready) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            cur_st_d = upd_next_q;
            if ((upd_next_q == C_GOAL) || (step_cnt_q == C_MAX_STEPS)) begin
               if (count_q == C_LAST_EP) begin
                  state_d = DONE;
               end else begin
                  count_d = count_q + 1'b1;
                  state_d = EP_START;
               end
            end else begin
               state_d = STEP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A start clears the error, but a stray step result in the same cycle
      // is still reported.
      if (i_start) begin
         err_d = 1'b0;
      end
      if (i_agent_valid && (state_q != WAIT_AGENT)) begin
         err_d = 1'b1;
      end

      // Abort overrides everything; the pending transfer is abandoned.
      if (i_stop) begin
         state_d    = IDLE;
         count_d    = '0;
         step_cnt_d = '0;
      end
   end

   // Controller registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         step_cnt_q <= '0;
         cur_st_q   <= '0;
         count_q    <= '0;
         upd_st_q   <= '0;
         upd_next_q <= '0;
         upd_at_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_cnt_q <= step_cnt_d;
         cur_st_q   <= cur_st_d;
         count_q    <= count_d;
         upd_st_q   <= upd_st_d;
         upd_next_q <= upd_next_d;
         upd_at_q   <= upd_at_d;
         err_q      <= err_d;
      end
   end

   ql_lfsr16 #(
      .SEED      (LFSR_SEED)
   ) u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_advance (i_re_random),
      .o_lfsr    (lfsr_state)
   );

   // Random action is the low LFSR byte reduced into the legal action range.
   assign o_at_random   = ACTIONS_WIDTH'(32'(lfsr_state & 16'h00FF) % 32'(NUM_ACTIONS));

   assign o_agent_valid = (state_q == STEP);
   assign o_agent_st    = cur_st_q;
   assign o_count       = count_q;
   // Gated by i_stop so an abort withdraws the transfer in the same cycle.
   assign o_upd_valid   = (state_q == UPDATE) && !i_stop;
   assign o_upd_st      = upd_st_q;
   assign o_upd_at      = upd_at_q;
   assign o_upd_next_st = upd_next_q;
   assign o_busy        = (state_q != IDLE) && (state_q != DONE);
   assign o_done        = (state_q == DONE);
   assign o_err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ql_episode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ql_episode_ctrl
//  Purpose  : Self-checking bench for ql_episode_ctrl with a reactive agent
//             model (one-cycle latency) and directed episode vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ql_episode_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_start, i_stop, i_re_random, i_agent_valid, i_upd_ready;
   logic [3:0]  i_first_st, i_st, i_next_st;
   logic [1:0]  i_at;
   logic        o_agent_valid, o_upd_valid, o_busy, o_done, o_err;
   logic [3:0]  o_agent_st, o_upd_st, o_upd_next_st;
   logic [1:0]  o_at_random, o_upd_at;
   logic [15:0] o_count;

   always #5 clk = ~clk;

   ql_episode_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (i_start),
      .i_stop        (i_stop),
      .i_first_st    (i_first_st),
      .o_agent_valid (o_agent_valid),
      .o_agent_st    (o_agent_st),
      .o_count       (o_count),
      .o_at_random   (o_at_random),
      .i_re_random   (i_re_random),
      .i_agent_valid (i_agent_valid),
      .i_st          (i_st),
      .i_next_st     (i_next_st),
      .i_at          (i_at),
      .o_upd_valid   (o_upd_valid),
      .o_upd_st      (o_upd_st),
      .o_upd_next_st (o_upd_next_st),
      .o_upd_at      (o_upd_at),
      .i_upd_ready   (i_upd_ready),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_err         (o_err)
   );

   int n_chk = 0;
   int n_err = 0;

   // Agent model state and activity counters
   bit         pend, stray;
   logic [3:0] pend_st, pend_next;
   logic [1:0] pend_at;
   int         step_no, n_agent, n_hs, cyc, first_agent_st;
   int         cfg_delta, cfg_goal_at;

   typedef struct {
      logic [3:0] first;
      int         delta;
      int         goal_at;
      int         steps;
   } ep_vec_t;

   ep_vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] gold_lfsr(input logic [15:0] s);
      logic [15:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   function automatic logic [3:0] agent_next(input logic [3:0] st);
      if (cfg_goal_at != 0) return (step_no == cfg_goal_at) ? 4'd15 : st;
      return st + 4'(cfg_delta);
   endfunction

   // One clock: agent reacts at the falling edge, activity is counted just after.
   task automatic tick();
      @(negedge clk);
      i_agent_valid = 1'b0;
      if (pend) begin
         i_agent_valid = 1'b1;
         i_st          = pend_st;
         i_at          = pend_at;
         i_next_st     = pend_next;
         pend          = 1'b0;
      end else if (stray) begin
         i_agent_valid = 1'b1;
         stray         = 1'b0;
      end
      if (o_agent_valid) begin
         step_no++;
         n_agent++;
         if (step_no == 1) first_agent_st = int'(o_agent_st);
         pend      = 1'b1;
         pend_st   = o_agent_st;
         pend_at   = 2'(o_agent_st % 3);
         pend_next = agent_next(o_agent_st);
      end
      #1;
      if (o_upd_valid && i_upd_ready) n_hs++;
      cyc++;
   endtask

   task automatic clear_counts();
      n_agent = 0; n_hs = 0; cyc = 0; step_no = 0; first_agent_st = -1;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_upd(input string name);
      for (int k = 0; k < 100 && !o_upd_valid; k++) tick();
      check(name, o_upd_valid, 1);
   endtask

   initial begin
      logic [15:0] model;
      int          prev_cnt, seq_bad;

      rst_n = 1'b0; i_start = 0; i_stop = 0; i_re_random = 0; i_agent_valid = 0;
      i_upd_ready = 1; i_first_st = 0; i_st = 0; i_next_st = 0; i_at = 0;
      pend = 0; stray = 0; cfg_delta = 1; cfg_goal_at = 0;
      clear_counts();

      vecs[0] = '{4'd0,  1, 0,  15};   // goal path from 0
      vecs[1] = '{4'd10, 1, 0,  5};
      vecs[2] = '{4'd14, 1, 0,  1};
      vecs[3] = '{4'd15, 0, 0,  1};    // start on goal: still one step
      vecs[4] = '{4'd3,  0, 0,  64};   // never reaches goal: step limit
      vecs[5] = '{4'd0,  5, 0,  3};
      vecs[6] = '{4'd1,  2, 0,  7};
      vecs[7] = '{4'd2,  0, 64, 64};   // goal and limit on the same step
      vecs[8] = '{4'd2,  0, 63, 63};

      tick(); tick();
      rst_n = 1'b1;
      tick();
      model = 16'hACE1;
      check("reset_busy",   o_busy, 0);
      check("reset_done",   o_done, 0);
      check("reset_count",  o_count, 0);
      check("reset_random", o_at_random, 32'(model[7:0] % 3));

      // ---------------- episode vectors ----------------
      cfg_delta = vecs[0].delta; cfg_goal_at = vecs[0].goal_at; i_first_st = vecs[0].first;
      pulse_start();
      check("start_busy",  o_busy, 1);
      check("start_count", o_count, 0);
      for (int i = 0; i < 9; i++) begin
         clear_counts();
         cfg_delta   = vecs[i].delta;
         cfg_goal_at = vecs[i].goal_at;
         i_first_st  = vecs[i].first;
         for (int k = 0; k < 2000 && o_count != 16'(i + 1); k++) tick();
         check($sformatf("ep%0d_steps", i),    n_agent, vecs[i].steps);
         check($sformatf("ep%0d_handshk", i),  n_hs, vecs[i].steps);
         check($sformatf("ep%0d_cycles", i),   cyc, 4 * vecs[i].steps + 1);
         check($sformatf("ep%0d_first_st", i), first_agent_st, int'(vecs[i].first));
      end

      // ---------------- backpressure ----------------
      cfg_delta = 1; cfg_goal_at = 0; i_first_st = 4'd0; i_upd_ready = 1'b0;
      wait_upd("bp_valid_seen");
      for (int j = 0; j < 5; j++) begin
         tick();
         check("bp_valid_held", o_upd_valid, 1);
         check("bp_payload", {o_upd_st, o_upd_at, o_upd_next_st}, {4'd0, 2'd0, 4'd1});
         check("bp_no_agent", o_agent_valid, 0);
      end
      i_upd_ready = 1'b1;
      tick();
      check("bp_check_no_valid", o_upd_valid, 0);
      check("bp_check_no_agent", o_agent_valid, 0);
      tick();
      check("bp_next_step", o_agent_valid, 1);
      check("bp_next_st",   o_agent_st, 1);

      // ---------------- abort in UPDATE ----------------
      i_upd_ready = 1'b0;
      wait_upd("abort_upd_seen");
      i_stop = 1'b1; pend = 1'b0;
      #1;
      check("abort_valid_drop", o_upd_valid, 0);
      tick();
      i_stop = 1'b0;
      check("abort_idle",  o_busy, 0);
      check("abort_valid", o_upd_valid, 0);
      check("abort_count", o_count, 0);

      // ---------------- stray agent result ----------------
      i_upd_ready = 1'b1;
      check("err_clean", o_err, 0);
      pulse_start();
      wait_upd("err_upd_seen");
      stray = 1'b1;
      tick();
      check("err_not_yet", o_err, 0);
      tick();
      check("err_set", o_err, 1);
      tick(); tick(); tick();
      check("err_sticky", o_err, 1);
      i_stop = 1'b1; pend = 1'b0;
      tick();
      i_stop = 1'b0; pend = 1'b0;
      check("err_after_stop", o_err, 1);

      // ---------------- full goal-path run ----------------
      cfg_delta = 1; cfg_goal_at = 0; i_first_st = 4'd0;
      pulse_start();
      check("err_cleared", o_err, 0);
      clear_counts();
      prev_cnt = 0; seq_bad = 0;
      for (int k = 0; k < 30000 && !o_done; k++) begin
         tick();
         if (int'(o_count) != prev_cnt) begin
            if (int'(o_count) != prev_cnt + 1) seq_bad++;
            prev_cnt = int'(o_count);
         end
         i_start = (k == 100);   // ignored while busy
      end
      i_start = 1'b0;
      check("run_done",     o_done, 1);
      check("run_not_busy", o_busy, 0);
      check("run_count",    o_count, 299);
      check("run_steps",    n_agent, 300 * 15);
      check("run_handshk",  n_hs, 300 * 15);
      check("run_count_seq", seq_bad, 0);
      tick(); tick();
      check("done_hold", o_done, 1);
      pulse_start();
      check("restart_busy",  o_busy, 1);
      check("restart_done",  o_done, 0);
      check("restart_count", o_count, 0);

      // ---------------- reset mid-run ----------------
      i_re_random = 1'b1;
      tick(); tick(); tick();
      i_re_random = 1'b0;
      for (int k = 0; k < 200 && o_count != 16'd1; k++) tick();
      check("rst_pre_count", o_count, 1);
      wait_upd("rst_pre_upd");
      rst_n = 1'b0; pend = 1'b0;
      #1;
      check("rst_count", o_count, 0);
      check("rst_outputs",
            {o_agent_valid, o_agent_st, o_upd_valid, o_upd_st, o_upd_at, o_upd_next_st, o_busy, o_done, o_err},
            0);
      check("rst_random", o_at_random, 32'(model[7:0] % 3));
      tick();
      rst_n = 1'b1;
      tick();

      // ---------------- random action sequence ----------------
      i_re_random = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         tick();
         if (k == 999) i_re_random = 1'b0;
         model = gold_lfsr(model);
         check("rand_seq",   o_at_random, 32'(model[7:0] % 3));
         check("rand_range", (o_at_random < 2'd3), 1);
      end
      tick(); tick();
      check("rand_hold", o_at_random, 32'(model[7:0] % 3));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
